alu_result_stage: RTL and testbench
===================================

// Module: alu_result_stage
// PURPOSE
//  Receives each ALU result (BusW) with its instruction context and resolves branches.
//  Zero is recomputed from BusW. CBZ/CBNZ/B become a PC redirect plus a wrong-path squash.
//  Surviving results go to the MEM/WB side through a 2-entry valid/ready buffer.
//  Sits between the ALU and the data-memory stage. Runs in the ALU's clock domain.
// PARAMETERS
//  DATA_W    64  ALU result width (BusW)
//  PC_W      64  program counter width
//  REG_AW    5   destination register index width
//  SQUASH_N  2   wrong-path accepts discarded after a taken branch (1..7)
//  CNT_W     32  retired-instruction counter width
// PORTS
//  Clk             in   1       single clock, rising edge
//  Reset_L         in   1       reset, asynchronous, active-low
//  in_valid        in   1       upstream result valid
//  in_ready        out  1       stage can accept (registered, = count<2)
//  in_BusW         in   DATA_W  ALU result
//  in_PC           in   PC_W    PC of the instruction
//  in_BrOffset     in   PC_W    branch offset, already scaled (<<2) and sign-extended
//  in_BrKind       in   2       00 none, 01 B, 10 CBZ, 11 CBNZ
//  in_Rd           in   REG_AW  destination register
//  in_RegWrite     in   1       writes Rd
//  out_valid       out  1       buffered result valid
//  out_ready       in   1       downstream accepts
//  out_BusW        out  DATA_W  head-entry result
//  out_Rd          out  REG_AW  head-entry destination
//  out_RegWrite    out  1       head-entry write enable (0 for branches)
//  redirect_valid  out  1       one-cycle pulse: fetch must load redirect_PC
//  redirect_PC     out  PC_W    branch target
//  retired_cnt     out  CNT_W   count of entries popped downstream
// BEHAVIOUR
//  Reset (Reset_L=0, async)
//   - Buffer empty. in_ready=1, out_valid=0, out_BusW/out_Rd/out_RegWrite=0.
//   - redirect_valid=0, redirect_PC=0, retired_cnt=0, FSM=RUN, squash count=0.
//   - Reset mid-operation discards all entries and any pending squash. No redirect is emitted.
//  Handshake
//   - Accept = in_valid & in_ready. Pop = out_valid & out_ready.
//   - Payload is stable while out_valid=1 and out_ready=0.
//   - Count<2 (in_ready=1) at the active edge: accept and pop may both occur.
//   - Count=1 with accept and pop in the same cycle: count stays 1, new data queued behind head.
//   - Count=2: in_ready=0. Pop at count=2 raises in_ready on the next cycle.
//   - Accept->out_valid latency is 1 cycle when empty. Ordering is strictly FIFO.
//  Branch resolution, on accept in RUN
//   - zero = (in_BusW == 0), full DATA_W compare.
//   - taken = B | (CBZ & zero) | (CBNZ & ~zero).
//   - target = in_PC + in_BrOffset, modulo 2^PC_W; wrap is silent.
//   - Taken: redirect_valid=1 for exactly the next cycle with redirect_PC=target; FSM goes to SQUASH.
//   - Branch entries are still enqueued with RegWrite forced to 0.
//  FSM
//   - RUN: normal. A taken branch moves to SQUASH with squash count=SQUASH_N.
//   - SQUASH: in_ready follows the buffer rule. Each accept is dropped (not enqueued, not counted) and decrements squash count.
//   - SQUASH -> RUN when squash count reaches 0.
//   - Branches accepted during SQUASH are dropped and never redirect.
//   - Pops continue normally during SQUASH.
//  retired_cnt: +1 per pop, wraps from 2^CNT_W-1 to 0.
//  redirect_PC holds its last value when redirect_valid=0.
// STRUCTURE
//  Package alu_stage_pkg
//   - BrKind encodings (BR_NONE/BR_B/BR_CBZ/BR_CBNZ).
//   - FSM state enum (ST_RUN, ST_SQUASH).
//   - ALUCtrl opcode constants shared with the ALU.
//  Sub-module skid_fifo2
//   - Parameterised 2-entry valid/ready buffer, width = DATA_W+REG_AW+1.
//   - Owns count, in_ready, out_valid.
//  Top level: branch compare, target adder, squash FSM, redirect register, retired counter.
// TESTING
//  1. Reset: Reset_L low mid-stream with 2 entries queued -> out_valid=0, in_ready=1, retired_cnt=0 asynchronously.
//  2. Back-pressure: 3 ADD results (BusW=5,7,9), out_ready=0 -> in_ready=0 after 2.
//     Release -> pops 5,7,9 in order, retired_cnt=3.
//  3. CBZ taken: BusW=0, PC=0x100, off=0x20 -> redirect_valid for 1 cycle, redirect_PC=0x120.
//     Next 2 accepts dropped, 3rd enqueued.
//  4. CBNZ with BusW=0x1_0000_0000 -> taken (64-bit compare). CBZ same value -> no redirect.
//  5. Wrap: PC=0xFFFF_FFFF_FFFF_FFF0, off=0x20 -> redirect_PC=0x10.
//     retired_cnt preloaded near max -> wraps to 0.
//  6. Simultaneous: count=1, accept+pop same edge -> count 1, order kept.
//     Taken B during SQUASH -> no second redirect.

Source files
------------

// File: rtl/alu_stage_pkg.sv
// Shared encodings for the ALU result stage: branch kinds, squash FSM states,
// ALU control opcodes and the branch-taken rule.
package alu_stage_pkg;

   typedef enum logic [1:0] {
      BR_NONE = 2'b00,
      BR_B    = 2'b01,
      BR_CBZ  = 2'b10,
      BR_CBNZ = 2'b11
   } br_kind_e;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_SQUASH = 1'b1
   } stage_state_e;

   localparam logic [3:0] ALU_AND   = 4'b0000;
   localparam logic [3:0] ALU_ORR   = 4'b0001;
   localparam logic [3:0] ALU_ADD   = 4'b0010;
   localparam logic [3:0] ALU_SUB   = 4'b0110;
   localparam logic [3:0] ALU_PASSB = 4'b0111;

   function automatic logic br_taken(input br_kind_e kind, input logic zero);
      logic taken;
      case (kind)
         BR_B:    taken = 1'b1;
         BR_CBZ:  taken = zero;
         BR_CBNZ: taken = ~zero;
         default: taken = 1'b0;
      endcase
      return taken;
   endfunction

endpackage

// File: rtl/alu_result_stage_if.sv
// Upstream result bus, downstream MEM/WB bus, fetch redirect and retire count
// of the ALU result stage. The stage takes the slave view.
interface alu_result_stage_if #(
   parameter int DATA_W = 64,
   parameter int PC_W   = 64,
   parameter int REG_AW = 5,
   parameter int CNT_W  = 32
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_BusW;
   logic [PC_W-1:0]   in_PC;
   logic [PC_W-1:0]   in_BrOffset;
   logic [1:0]        in_BrKind;
   logic [REG_AW-1:0] in_Rd;
   logic              in_RegWrite;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_BusW;
   logic [REG_AW-1:0] out_Rd;
   logic              out_RegWrite;
   logic              redirect_valid;
   logic [PC_W-1:0]   redirect_PC;
   logic [CNT_W-1:0]  retired_cnt;

   modport slave (
      input  in_valid, in_BusW, in_PC, in_BrOffset, in_BrKind, in_Rd, in_RegWrite, out_ready,
      output in_ready, out_valid, out_BusW, out_Rd, out_RegWrite,
      output redirect_valid, redirect_PC, retired_cnt
   );

   modport master (
      output in_valid, in_BusW, in_PC, in_BrOffset, in_BrKind, in_Rd, in_RegWrite, out_ready,
      input  in_ready, out_valid, out_BusW, out_Rd, out_RegWrite,
      input  redirect_valid, redirect_PC, retired_cnt
   );
endinterface

// File: rtl/skid_fifo2.sv
// Two-entry valid/ready buffer. o_ready depends only on the stored count, so
// there is no combinational path from i_ready to o_ready.
module skid_fifo2 #(
   parameter int W = 70
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_valid,
   output logic         o_ready,
   input  logic [W-1:0] i_data,
   output logic         o_valid,
   input  logic         i_ready,
   output logic [W-1:0] o_data
);
   logic       r_wr_ptr;
   logic       r_rd_ptr;
   logic [1:0] r_count;
   logic       w_push;
   logic       w_pop;

   assign o_ready = (r_count != 2'd2);
   assign o_valid = (r_count != 2'd0);
   assign w_push  = i_valid & o_ready;
   assign w_pop   = o_valid & i_ready;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_entry
         logic [W-1:0] r_data;
         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n)
               r_data <= '0;
            else if (w_push && (r_wr_ptr == 1'(gi)))
               r_data <= i_data;
         end
      end
   endgenerate

   assign o_data = r_rd_ptr ? g_entry[1].r_data : g_entry[0].r_data;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) r_wr_ptr <= ~r_wr_ptr;
         if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end
endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: resolves B/CBZ/CBNZ, redirects fetch, squashes wrong-path
// results and buffers survivors toward MEM/WB.
module alu_result_stage
   import alu_stage_pkg::*;
#(
   parameter int DATA_W   = 64,
   parameter int PC_W     = 64,
   parameter int REG_AW   = 5,
   parameter int SQUASH_N = 2,
   parameter int CNT_W    = 32
) (
   input logic               Clk,
   input logic               Reset_L,
   alu_result_stage_if.slave bus
);
   localparam int         ENT_W   = DATA_W + REG_AW + 1;
   localparam logic [2:0] SQ_INIT = 3'(SQUASH_N);

   stage_state_e      r_state;
   stage_state_e      w_state_next;
   logic [2:0]        r_squash_cnt;
   logic [2:0]        w_squash_next;
   logic              w_redirect_next;
   logic              r_redirect_valid;
   logic [PC_W-1:0]   r_redirect_pc;
   logic [CNT_W-1:0]  r_retired_cnt;
   logic              w_fifo_ready;
   logic              w_fifo_valid;
   logic              w_accept;
   logic              w_taken;
   logic [PC_W-1:0]   w_target;
   br_kind_e          w_kind;
   logic [ENT_W-1:0]  w_in_entry;
   logic [ENT_W-1:0]  w_out_entry;

   assign w_kind     = br_kind_e'(bus.in_BrKind);
   assign w_accept   = bus.in_valid & w_fifo_ready;
   assign w_taken    = br_taken(w_kind, bus.in_BusW == '0);
   assign w_target   = bus.in_PC + bus.in_BrOffset;
   // Branches never write a register, taken or not.
   assign w_in_entry = {bus.in_BusW, bus.in_Rd, bus.in_RegWrite & (w_kind == BR_NONE)};

   skid_fifo2 #(.W(ENT_W)) u_fifo (
      .i_clk   (Clk),
      .i_rst_n (Reset_L),
      .i_valid (bus.in_valid & (r_state == ST_RUN)),
      .o_ready (w_fifo_ready),
      .i_data  (w_in_entry),
      .o_valid (w_fifo_valid),
      .i_ready (bus.out_ready),
      .o_data  (w_out_entry)
   );

   always_comb begin
      w_state_next    = r_state;
      w_squash_next   = r_squash_cnt;
      w_redirect_next = 1'b0;
      case (r_state)
         ST_RUN: begin
            if (w_accept && w_taken) begin
               w_state_next    = ST_SQUASH;
               w_squash_next   = SQ_INIT;
               w_redirect_next = 1'b1;
            end
         end
         ST_SQUASH: begin
            if (w_accept) begin
               w_squash_next = r_squash_cnt - 3'd1;
               if (r_squash_cnt == 3'd1) w_state_next = ST_RUN;
            end
         end
         default: w_state_next = ST_RUN;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_L) begin
      if (!Reset_L) begin
         r_state          <= ST_RUN;
         r_squash_cnt     <= 3'd0;
         r_redirect_valid <= 1'b0;
         r_redirect_pc    <= '0;
         r_retired_cnt    <= '0;
      end else begin
         r_state          <= w_state_next;
         r_squash_cnt     <= w_squash_next;
         r_redirect_valid <= w_redirect_next;
         if (w_redirect_next) r_redirect_pc <= w_target;
         if (w_fifo_valid && bus.out_ready) r_retired_cnt <= r_retired_cnt + CNT_W'(1);
      end
   end

   assign bus.in_ready       = w_fifo_ready;
   assign bus.out_valid      = w_fifo_valid;
   assign {bus.out_BusW, bus.out_Rd, bus.out_RegWrite} = w_out_entry;
   assign bus.redirect_valid = r_redirect_valid;
   assign bus.redirect_PC    = r_redirect_pc;
   assign bus.retired_cnt    = r_retired_cnt;
endmodule

// File: tb/tb_alu_result_stage.sv
// Random and directed stimulus for alu_result_stage, checked every cycle
// against a queue-based reference model of the stage.
module tb_alu_result_stage;
   import alu_stage_pkg::*;

   localparam int DATA_W   = 64;
   localparam int PC_W     = 64;
   localparam int REG_AW   = 5;
   localparam int SQUASH_N = 2;
   localparam int CNT_W    = 5;   // small so retire-counter wrap happens quickly

   logic Clk = 1'b0;
   logic Reset_L;
   always #5 Clk = ~Clk;

   alu_result_stage_if #(.DATA_W(DATA_W), .PC_W(PC_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

   alu_result_stage #(
      .DATA_W(DATA_W), .PC_W(PC_W), .REG_AW(REG_AW), .SQUASH_N(SQUASH_N), .CNT_W(CNT_W)
   ) dut (
      .Clk     (Clk),
      .Reset_L (Reset_L),
      .bus     (bus)
   );

   typedef struct {
      logic [63:0] w;
      logic [4:0]  rd;
      logic        rw;
   } ent_t;

   ent_t             q[$];
   int               checks   = 0;
   int               failures = 0;
   int               squash_left;
   logic             exp_redir;
   logic [63:0]      exp_pc;
   logic [CNT_W-1:0] exp_cnt;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s obs=0x%0h exp=0x%0h t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      squash_left = 0;
      exp_redir   = 1'b0;
      exp_pc      = '0;
      exp_cnt     = '0;
   endtask

   task automatic check_outputs();
      check_eq("in_ready",       64'(bus.in_ready),       64'(q.size() < 2));
      check_eq("out_valid",      64'(bus.out_valid),      64'(q.size() > 0));
      if (q.size() > 0) begin
         check_eq("out_BusW",     bus.out_BusW,           q[0].w);
         check_eq("out_Rd",       64'(bus.out_Rd),        64'(q[0].rd));
         check_eq("out_RegWrite", 64'(bus.out_RegWrite),  64'(q[0].rw));
      end
      check_eq("redirect_valid", 64'(bus.redirect_valid), 64'(exp_redir));
      check_eq("redirect_PC",    bus.redirect_PC,         exp_pc);
      check_eq("retired_cnt",    64'(bus.retired_cnt),    64'(exp_cnt));
   endtask

   // One cycle: check outputs at the falling edge, drive new inputs, then
   // advance the model to what must hold after the next rising edge.
   task automatic step(input logic v, input logic [63:0] w, input logic [63:0] pc,
                       input logic [63:0] off, input logic [1:0] kind, input logic [4:0] rd,
                       input logic rw, input logic ordy, output logic acc);
      logic pop;
      logic taken;
      ent_t e;
      @(negedge Clk);
      check_outputs();
      bus.in_valid    = v;
      bus.in_BusW     = w;
      bus.in_PC       = pc;
      bus.in_BrOffset = off;
      bus.in_BrKind   = kind;
      bus.in_Rd       = rd;
      bus.in_RegWrite = rw;
      bus.out_ready   = ordy;
      acc = v && (q.size() < 2);
      pop = (q.size() > 0) && ordy;
      if (pop) begin
         e = q.pop_front();
         exp_cnt = exp_cnt + 1'b1;
      end
      exp_redir = 1'b0;
      if (acc) begin
         if (squash_left == 0) begin
            taken = (kind == 2'd1) || (kind == 2'd2 && w == 0) || (kind == 2'd3 && w != 0);
            e.w  = w;
            e.rd = rd;
            e.rw = rw && (kind == 2'd0);
            q.push_back(e);
            if (taken) begin
               exp_redir   = 1'b1;
               exp_pc      = pc + off;
               squash_left = SQUASH_N;
            end
            $display("ACCEPT t=%0t busw=0x%0h kind=%0d taken=%0d", $time, w, kind, taken);
         end else begin
            squash_left--;
            $display("DROP   t=%0t busw=0x%0h kind=%0d", $time, w, kind);
         end
      end
   endtask

   task automatic push_op(input logic [63:0] w, input logic ordy, output logic acc);
      step(1'b1, w, 64'h40, 64'h0, 2'd0, 5'(w), 1'b1, ordy, acc);
   endtask

   task automatic branch(input logic [1:0] kind, input logic [63:0] w, input logic [63:0] pc,
                         input logic [63:0] off, output logic acc);
      step(1'b1, w, pc, off, kind, 5'd9, 1'b1, 1'b1, acc);
   endtask

   task automatic idle(input int n);
      logic acc;
      for (int i = 0; i < n; i++) step(1'b0, 64'h0, 64'h0, 64'h0, 2'd0, 5'd0, 1'b0, 1'b1, acc);
   endtask

   task automatic settle();
      @(posedge Clk);
      #1;
   endtask

   logic acc;

   initial begin
      Reset_L = 1'b0;
      bus.in_valid = 1'b0; bus.in_BusW = '0; bus.in_PC = '0; bus.in_BrOffset = '0;
      bus.in_BrKind = 2'd0; bus.in_Rd = '0; bus.in_RegWrite = 1'b0; bus.out_ready = 1'b0;
      model_reset();
      repeat (2) @(negedge Clk);
      check_eq("rst_out_valid",    64'(bus.out_valid),      64'd0);
      check_eq("rst_in_ready",     64'(bus.in_ready),       64'd1);
      check_eq("rst_out_BusW",     bus.out_BusW,            64'd0);
      check_eq("rst_out_Rd",       64'(bus.out_Rd),         64'd0);
      check_eq("rst_out_RegWrite", 64'(bus.out_RegWrite),   64'd0);
      check_eq("rst_redir_valid",  64'(bus.redirect_valid), 64'd0);
      check_eq("rst_redir_pc",     bus.redirect_PC,         64'd0);
      check_eq("rst_retired",      64'(bus.retired_cnt),    64'd0);
      Reset_L = 1'b1;

      // Back-pressure: three ADD results with the sink stalled.
      push_op(64'd5, 1'b0, acc);
      push_op(64'd7, 1'b0, acc);
      push_op(64'd9, 1'b0, acc);
      check_eq("bp_third_refused", 64'(acc), 64'd0);
      for (int i = 0; i < 4 && !acc; i++) push_op(64'd9, 1'b1, acc);
      check_eq("bp_third_accepted", 64'(acc), 64'd1);
      idle(3);
      settle();
      check_eq("bp_retired", 64'(bus.retired_cnt), 64'd3);

      // CBZ taken, then two wrong-path results dropped and the third kept.
      branch(2'd2, 64'h0, 64'h100, 64'h20, acc);
      settle();
      check_eq("cbz_redir_valid", 64'(bus.redirect_valid), 64'd1);
      check_eq("cbz_redir_pc",    bus.redirect_PC,         64'h120);
      push_op(64'd11, 1'b1, acc);
      push_op(64'd12, 1'b1, acc);
      push_op(64'd13, 1'b1, acc);
      settle();
      check_eq("cbz_kept_valid", 64'(bus.out_valid), 64'd1);
      check_eq("cbz_kept_busw",  bus.out_BusW,       64'd13);

      // Upper-half-only nonzero value: CBNZ taken, CBZ not.
      idle(2);
      branch(2'd3, 64'h1_0000_0000, 64'h2000, 64'h40, acc);
      settle();
      check_eq("cbnz_redir_pc", bus.redirect_PC, 64'h2040);
      push_op(64'd21, 1'b1, acc);
      push_op(64'd22, 1'b1, acc);
      branch(2'd2, 64'h1_0000_0000, 64'h3000, 64'h8, acc);
      settle();
      check_eq("cbz_nz_no_redir", 64'(bus.redirect_valid), 64'd0);
      check_eq("cbz_nz_pc_held",  bus.redirect_PC,         64'h2040);

      // Target wrap, then a taken B inside the squash window.
      idle(1);
      branch(2'd1, 64'h7, 64'hFFFF_FFFF_FFFF_FFF0, 64'h20, acc);
      settle();
      check_eq("wrap_redir_pc", bus.redirect_PC, 64'h10);
      branch(2'd1, 64'h7, 64'h500, 64'h4, acc);
      settle();
      check_eq("sq_b_no_redir", 64'(bus.redirect_valid), 64'd0);
      push_op(64'd31, 1'b1, acc);

      // Accept and pop on the same edge with one entry queued.
      idle(2);
      push_op(64'hAA, 1'b0, acc);
      push_op(64'hBB, 1'b1, acc);
      settle();
      check_eq("sim_out_valid", 64'(bus.out_valid), 64'd1);
      check_eq("sim_out_busw",  bus.out_BusW,       64'hBB);
      check_eq("sim_in_ready",  64'(bus.in_ready),  64'd1);
      idle(2);

      // Random traffic; enough pops to wrap the retire counter.
      for (int i = 0; i < 400; i++) begin
         logic [63:0] w;
         logic [1:0]  kind;
         w    = ($urandom_range(0, 3) == 0) ? 64'h0 : {32'($urandom), 32'($urandom)};
         kind = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
         step($urandom_range(0, 3) != 0, w, {32'($urandom), 32'($urandom)},
              {32'($urandom), 32'($urandom)}, kind, 5'($urandom), 1'($urandom),
              $urandom_range(0, 3) != 0, acc);
      end

      // Asynchronous reset with two entries queued.
      idle(3);
      for (int i = 0; i < 10 && q.size() < 2; i++) push_op(64'h50 + 64'(i), 1'b0, acc);
      check_eq("pre_rst_two_queued", 64'(bus.out_valid), 64'(q.size() > 0));
      @(negedge Clk);
      bus.in_valid = 1'b0;
      #2 Reset_L = 1'b0;
      #1;
      check_eq("async_rst_out_valid", 64'(bus.out_valid),      64'd0);
      check_eq("async_rst_in_ready",  64'(bus.in_ready),       64'd1);
      check_eq("async_rst_retired",   64'(bus.retired_cnt),    64'd0);
      check_eq("async_rst_redir",     64'(bus.redirect_valid), 64'd0);
      @(negedge Clk);
      Reset_L = 1'b1;
      model_reset();

      // No squash survives reset: the first result afterwards is kept.
      push_op(64'h77, 1'b0, acc);
      settle();
      check_eq("post_rst_busw", bus.out_BusW, 64'h77);
      idle(3);
      @(negedge Clk);
      check_outputs();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
